sync_fifo_gen: RTL
==================

# sync_fifo_gen

Parametrised synchronous FIFO for the sensor → FIFO → DAQ path. It replaces the fixed 10-bit × 32 generated core with a behavioural block of configurable width and depth. It adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, and an optional first-word-fall-through read mode. It targets inferred distributed/block RAM, with no vendor IP.

## Interface
- WIDTH, 10, data word width in bits (≥1)
- DEPTH, 32, number of entries; power of 2, ≥4
- AF_THRESH, DEPTH-2, AlmostFull asserts when occupancy ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 2, AlmostEmpty asserts when occupancy ≤ AE_THRESH (0..DEPTH-1)
- clk  input  1  system clock (on-board 100 MHz); all logic on rising edge
- Reset  input  1  synchronous reset, active-low
- WrEnable  input  1  write request
- WrData  input  WIDTH  write data
- RdEnable  input  1  read request (pop)
- RdData  output  WIDTH  read data
- Full  output  1  occupancy == DEPTH
- Empty  output  1  occupancy == 0
- AlmostFull  output  1  occupancy ≥ AF_THRESH
- AlmostEmpty  output  1  occupancy ≤ AE_THRESH
- DataCount  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- Overflow  output  1  sticky: a write was attempted while Full
- Underflow  output  1  sticky: a read was attempted while Empty
- ClearFlags  input  1  clears Overflow/Underflow

## Operation
- Storage is DEPTH×WIDTH memory. Write and read pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Write accepted iff WrEnable && !Full. The word is stored at wr_ptr and wr_ptr increments.
- Read accepted iff RdEnable && !Empty. rd_ptr increments.
- Flags are evaluated on registered state at the start of the cycle. A write while Full is dropped, even with a simultaneous accepted read.
- Occupancy update: +1 for an accepted write only; -1 for an accepted read only; unchanged for both or neither.
- Simultaneous write and read in a non-empty, non-full FIFO: both are accepted and the count is unchanged.
- Both requests while Empty: the write is accepted, the read is rejected, and Underflow sets.
- Rejected write (WrEnable && Full) sets Overflow. Rejected read (RdEnable && Empty) sets Underflow.
- Overflow and Underflow hold until ClearFlags=1 or Reset.
- ClearFlags has priority over a set in the same cycle: the flag reads 0 next cycle.
- Full, Empty, AlmostFull, AlmostEmpty and DataCount are all registered and derived from the next occupancy. They are mutually consistent every cycle.
- Reset (Reset=0 at a rising edge):
  - pointers and occupancy go to 0; memory contents are not cleared but become unreachable
  - Empty=1, AlmostEmpty=1, Full=0, AlmostFull=0, DataCount=0, Overflow=0, Underflow=0, RdData=0
  - a reset during traffic discards all queued data, and requests in that cycle are ignored

## Timing
- Write in cycle N: DataCount, Empty and the thresholds update after edge N+1.
- Standard mode read latency: a read accepted in cycle N presents its word on RdData after edge N+1. RdData holds its value until the next accepted read.
- Minimum write-to-data latency, standard mode: write at N, Empty low at N+1, read at N+1, data at N+2.
- Full throughput: one write and one read per cycle sustained, with no bubbles.
- No combinational path from inputs to any flag output.

## Configuration
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - RdData combinationally shows mem[rd_ptr] whenever Empty=0; RdEnable acknowledges and pops that word
  - write at N: data is visible on RdData with Empty=0 at N+1
  - RdData is don't-care while Empty=1; reset value does not apply
- Undefined: standard mode as in Timing, with registered RdData and 1-cycle read latency.
- All flag and count behaviour is identical in both modes.

## Test plan
- Reset/idle: Reset=0 for 2 cycles with WrEnable=RdEnable=1 → Empty=1, DataCount=0, RdData=0, no flag set.
- Fill/drain (WIDTH=10, DEPTH=32): write 0x000..0x01F, then write 0x3FF while Full →
  - Full=1 at DataCount=32; AlmostFull asserts at DataCount=30
  - Overflow=1; 0x3FF is not stored
  - 32 reads return 0x000..0x01F in order; Empty=1 after the last
- Underflow: RdEnable=1 while Empty → Underflow=1, DataCount stays 0; ClearFlags=1 → Underflow=0 next cycle.
- Simultaneous R/W: hold DataCount=5, drive both requests for 100 cycles with incrementing data → DataCount stays 5, output order preserved, pointers wrap 3+ times.
- Reset mid-operation: Reset=0 at DataCount=17 → next cycle DataCount=0, Empty=1; the next write/read pair returns the new word, not stale data.
- FWFT build (SYNC_FIFO_FWFT_EN): write 0x155 into an empty FIFO → cycle after the write, Empty=0 and RdData=0x155 before any RdEnable; one RdEnable → Empty=1.

Source files
------------

// File: rtl/sync_fifo_gen.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; the default build has registered RdData.
module sync_fifo_gen #(
    parameter int WIDTH     = 10,
    parameter int DEPTH     = 32,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic                     WrEnable,
    input  logic [WIDTH-1:0]         WrData,
    input  logic                     RdEnable,
    output logic [WIDTH-1:0]         RdData,
    output logic                     Full,
    output logic                     Empty,
    output logic                     AlmostFull,
    output logic                     AlmostEmpty,
    output logic [$clog2(DEPTH):0]   DataCount,
    output logic                     Overflow,
    output logic                     Underflow,
    input  logic                     ClearFlags
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q, afull_q, aempty_q;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic          wr_acc, rd_acc;

    // Acceptance is judged only on registered flags, so no input reaches a flag combinationally.
    assign wr_acc = WrEnable && !full_q;
    assign rd_acc = RdEnable && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ClearFlags ? 1'b0 : (ovf_q | (WrEnable & full_q));
        unf_d = ClearFlags ? 1'b0 : (unf_q | (RdEnable & empty_q));
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
            afull_q  <= (count_d >= CW'(AF_THRESH));
            aempty_q <= (count_d <= CW'(AE_THRESH));
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is never reset; stale words become unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (Reset && wr_acc) mem[wr_ptr_q] <= WrData;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign RdData = mem[rd_ptr_q];
`else
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (!Reset) begin
            rd_data_q <= '0;
        end else if (rd_acc) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    assign RdData = rd_data_q;
`endif

    assign Full        = full_q;
    assign Empty       = empty_q;
    assign AlmostFull  = afull_q;
    assign AlmostEmpty = aempty_q;
    assign DataCount   = count_q;
    assign Overflow    = ovf_q;
    assign Underflow   = unf_q;

endmodule
